// File: rtl/calc_entry_ctrl.sv
// Key-entry front end for the 3-bit calculator ALU: assembles A/S/B from key events,
// waits SETTLE_CYCLES for the combinational ALU, then holds the captured result.
module calc_entry_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [1:0] key_type,
  input  logic [2:0] key_data,
  output logic       key_ready,
  output logic       key_err,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [4:0] alu_r,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_dzf,
  output logic [4:0] res_data,
  output logic       res_zf,
  output logic       res_sf,
  output logic       res_dzf,
  output logic       res_valid,
  output logic       done_pulse
);

  // state   | meaning
  // IDLE    | nothing entered
  // HAVE_A  | operand A entered
  // HAVE_OP | A and select entered
  // HAVE_B  | A, select and B entered
  // EXEC    | waiting for the ALU to settle
  // DONE    | result captured and held
  typedef enum logic [2:0] {
    S_IDLE, S_HAVE_A, S_HAVE_OP, S_HAVE_B, S_EXEC, S_DONE
  } state_t;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLR   = 2'b11;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       r_key_err, r_done;
  logic [2:0] r_a, r_b;
  logic [1:0] r_s;
  logic [4:0] r_res;
  logic       r_zf, r_sf, r_dzf;

  logic w_clr, w_err, w_capture, w_load_cnt, w_ld_a, w_ld_b, w_ld_s;

  assign w_clr = key_valid && (key_type == K_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_capture  = 1'b0;
    w_load_cnt = 1'b0;
    w_ld_a     = 1'b0;
    w_ld_b     = 1'b0;
    w_ld_s     = 1'b0;
    if (w_clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (key_valid) begin
          if (key_type == K_DIGIT) begin w_ld_a = 1'b1; w_next = S_HAVE_A; end
          else w_err = 1'b1;
        end
        S_HAVE_A: if (key_valid) begin
          if (key_type == K_DIGIT) w_ld_a = 1'b1;
          else if (key_type == K_OP) begin w_ld_s = 1'b1; w_next = S_HAVE_OP; end
          else w_err = 1'b1;
        end
        S_HAVE_OP: if (key_valid) begin
          if (key_type == K_DIGIT) begin w_ld_b = 1'b1; w_next = S_HAVE_B; end
          else if (key_type == K_OP) w_ld_s = 1'b1;
          else w_err = 1'b1;
        end
        S_HAVE_B: if (key_valid) begin
          if (key_type == K_DIGIT) w_ld_b = 1'b1;
          else if (key_type == K_EQ) begin w_load_cnt = 1'b1; w_next = S_EXEC; end
          else w_err = 1'b1;
        end
        S_EXEC: begin
          // Keys arriving while the ALU settles are dropped, not queued.
          if (key_valid) w_err = 1'b1;
          if (r_cnt == 4'd0) begin w_capture = 1'b1; w_next = S_DONE; end
        end
        S_DONE: if (key_valid) begin
          if (key_type == K_DIGIT) begin w_ld_a = 1'b1; w_next = S_HAVE_A; end
          else if (key_type == K_EQ) begin w_load_cnt = 1'b1; w_next = S_EXEC; end
          else w_err = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready = (r_state != S_EXEC);
    res_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_key_err <= 1'b0;
      r_done    <= 1'b0;
      r_a       <= 3'd0;
      r_b       <= 3'd0;
      r_s       <= 2'd0;
      r_res     <= 5'd0;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_dzf     <= 1'b0;
    end else begin
      r_key_err <= w_err;
      r_done    <= w_capture;
      if (w_clr) begin
        r_cnt <= 4'd0;
        r_a   <= 3'd0;
        r_b   <= 3'd0;
        r_s   <= 2'd0;
        r_res <= 5'd0;
        r_zf  <= 1'b0;
        r_sf  <= 1'b0;
        r_dzf <= 1'b0;
      end else begin
        if (w_load_cnt) r_cnt <= CNT_INIT;
        else if (r_state == S_EXEC && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        if (w_ld_a) r_a <= key_data;
        if (w_ld_b) r_b <= key_data;
        if (w_ld_s) r_s <= key_data[1:0];
        if (w_capture) begin
          r_res <= alu_r;
          r_zf  <= alu_zf;
          r_sf  <= alu_sf;
          r_dzf <= alu_dzf;
        end
      end
    end
  end

  assign key_err    = r_key_err;
  assign done_pulse = r_done;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_s      = r_s;
  assign res_data   = r_res;
  assign res_zf     = r_zf;
  assign res_sf     = r_sf;
  assign res_dzf    = r_dzf;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios with literal expectations, then random
// key streams, all outputs compared every cycle against a flag-based entry model.
module tb_calc_entry_ctrl;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_type = 2'b00;
  logic [2:0] key_data = 3'd0;
  logic       key_ready, key_err;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_s;
  logic [4:0] alu_r;
  logic       alu_zf, alu_sf, alu_dzf;
  logic [4:0] res_data;
  logic       res_zf, res_sf, res_dzf, res_valid, done_pulse;

  int total = 0;
  int bad = 0;

  calc_entry_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_type(key_type),
    .key_data(key_data), .key_ready(key_ready), .key_err(key_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_dzf(alu_dzf),
    .res_data(res_data), .res_zf(res_zf), .res_sf(res_sf), .res_dzf(res_dzf),
    .res_valid(res_valid), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // Calculator ALU: 00 mul, 01 div, 10 add, 11 sub; packs {dzf, sf, zf, r}.
  function automatic logic [7:0] alu_fn(input logic [2:0] a, input logic [2:0] b,
                                        input logic [1:0] s);
    logic [4:0] r;
    logic dz;
    dz = 1'b0;
    case (s)
      2'd0: r = 5'({2'b00, a} * {2'b00, b});
      2'd1: if (b == 3'd0) begin dz = 1'b1; r = 5'd0; end
            else r = {2'b00, a / b};
      2'd2: r = {2'b00, a} + {2'b00, b};
      default: r = {2'b00, a} - {2'b00, b};
    endcase
    return {dz, r[4], (r == 5'd0), r};
  endfunction

  always_comb {alu_dzf, alu_sf, alu_zf, alu_r} = alu_fn(alu_a, alu_b, alu_s);

  // Entry model: progress flags plus a countdown of edges left until capture.
  bit got_a, got_op, got_b, shown, e_err, e_done;
  int exec_left;
  logic [2:0] m_a, m_b;
  logic [1:0] m_s;
  logic [4:0] m_r;
  logic m_zf, m_sf, m_dzf;

  task automatic model_clear();
    got_a = 0; got_op = 0; got_b = 0; shown = 0; exec_left = 0;
    m_a = 0; m_b = 0; m_s = 0; m_r = 0; m_zf = 0; m_sf = 0; m_dzf = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      e_err = 0; e_done = 0;
    end else begin
      e_err = 0; e_done = 0;
      if (key_valid && key_type == 2'd3) begin
        model_clear();
      end else if (exec_left > 0) begin
        if (key_valid) e_err = 1;
        exec_left--;
        if (exec_left == 0) begin
          {m_dzf, m_sf, m_zf, m_r} = alu_fn(m_a, m_b, m_s);
          shown = 1; e_done = 1;
        end
      end else if (key_valid) begin
        case (key_type)
          2'd0: if (shown) begin
                  m_a = key_data; shown = 0; got_a = 1; got_op = 0; got_b = 0;
                end else if (!got_a || !got_op) begin
                  m_a = key_data; got_a = 1;
                end else begin
                  m_b = key_data; got_b = 1;
                end
          2'd1: if (got_a && !got_b && !shown) begin m_s = key_data[1:0]; got_op = 1; end
                else e_err = 1;
          default: if (got_b) begin exec_left = SETTLE; shown = 0; end
                   else e_err = 1;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("key_ready", int'(key_ready), int'(exec_left == 0));
      chk("key_err", int'(key_err), int'(e_err));
      chk("done_pulse", int'(done_pulse), int'(e_done));
      chk("res_valid", int'(res_valid), int'(shown));
      chk("alu_a", int'(alu_a), int'(m_a));
      chk("alu_b", int'(alu_b), int'(m_b));
      chk("alu_s", int'(alu_s), int'(m_s));
      chk("res_data", int'(res_data), int'(m_r));
      chk("res_flags", int'({res_dzf, res_sf, res_zf}), int'({m_dzf, m_sf, m_zf}));
    end
  end

  task automatic key(input logic [1:0] t, input logic [2:0] d);
    key_valid = 1'b1; key_type = t; key_data = d;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2;
    chk("rst key_ready", int'(key_ready), 1);
    chk("rst outputs", int'({key_err, done_pulse, res_valid, alu_a, alu_b, alu_s, res_data}), 0);
    #10 rst_n = 1'b1;

    // 3 * 2 with done_pulse two edges after equals
    key(0, 3); key(1, 0); key(0, 2); key(2, 0);
    chk("t1 operands", int'({alu_a, alu_b, alu_s}), int'({3'd3, 3'd2, 2'd0}));
    chk("t1 ready in exec", int'(key_ready), 0);
    idle(1);
    chk("t1 no early done", int'(done_pulse), 0);
    idle(1);
    chk("t1 done", int'(done_pulse), 1);
    chk("t1 res", int'({res_valid, res_zf, res_sf, res_data}), int'({3'b100, 5'b00110}));
    idle(1);
    chk("t1 done one wide", int'(done_pulse), 0);

    // reset in the middle of EXEC
    key(3, 0); key(0, 3); key(1, 0); key(0, 2); key(2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid exec", int'({key_err, done_pulse, res_valid, alu_a, alu_b, alu_s, res_data}), 0);
    chk("rst mid ready", int'(key_ready), 1);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(3);
    chk("rst no done", int'({done_pulse, res_valid}), 0);

    // divide by zero, then re-execute
    key(0, 5); key(1, 1); key(0, 0); key(2, 0); idle(2);
    chk("t3 dzf", int'({done_pulse, res_valid, res_dzf}), 7);
    key(2, 0);
    chk("t3 reexec busy", int'({res_valid, key_ready}), 0);
    idle(2);
    chk("t3 dzf again", int'({done_pulse, res_valid, res_dzf}), 7);

    // illegal keys
    key(3, 0); key(2, 0);
    chk("t4 err1", int'(key_err), 1);
    key(2, 0);
    chk("t4 err back to back", int'(key_err), 1);
    key(0, 4);
    chk("t4 digit ok", int'({key_err, alu_a}), 4);
    key(2, 0);
    chk("t4 eq in have_a", int'({key_err, alu_a}), 12);
    key(1, 2); key(0, 1); key(2, 0); idle(2);
    chk("t4 capture", int'({done_pulse, res_data}), int'({1'b1, 5'd5}));

    // key dropped in EXEC, then clear on the last EXEC cycle
    key(3, 0); key(0, 6); key(1, 2); key(0, 1); key(2, 0);
    key(0, 5);
    chk("t5 drop", int'({key_err, key_ready, alu_b}), int'({2'b10, 3'd1}));
    key(3, 0);
    chk("t5 clear", int'({res_valid, done_pulse, key_ready, alu_a, alu_b}), int'({3'b001, 6'd0}));
    idle(1);
    chk("t5 no done", int'({done_pulse, res_valid}), 0);

    // overwrites
    key(0, 2); key(0, 7); key(1, 3); key(1, 2); key(0, 1); key(0, 3); key(2, 0);
    chk("t6 operands", int'({alu_a, alu_s, alu_b}), int'({3'd7, 2'd2, 3'd3}));
    idle(1);
    chk("t6 stable", int'({alu_a, alu_s, alu_b}), int'({3'd7, 2'd2, 3'd3}));
    idle(1);
    chk("t6 capture", int'({done_pulse, res_data}), int'({1'b1, 5'd10}));

    // random key stream
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) idle(1);
      else if (r < 19) key(3, 3'($urandom_range(0, 7)));
      else if (r < 55) key(0, 3'($urandom_range(0, 7)));
      else if (r < 75) key(1, 3'($urandom_range(0, 7)));
      else key(2, 3'($urandom_range(0, 7)));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
